// File: rtl/picorv32_wait_mem.sv
// Behavioural memory slave for the PicoRV32 native bus. It inserts fixed or LFSR-chosen wait
// states, and adds a tohost mailbox, out-of-range flagging and a backdoor preload port.
module picorv32_wait_mem #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned MIN_WAIT    = 0,
    parameter int unsigned MAX_WAIT    = 3,
    parameter bit          RAND_WAIT   = 1'b0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    localparam int unsigned AW         = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_valid,
    input  logic          mem_instr,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic          mem_ready,
    output logic [31:0]   mem_rdata,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic          tohost_valid,
    output logic [31:0]   tohost_data,
    output logic          err_oob,
    output logic [31:0]   access_count,
    output logic [31:0]   fetch_count
);

    localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
    localparam logic [7:0]  WAIT_MASK = 8'(MAX_WAIT - MIN_WAIT);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q;
    logic [31:2] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;
    logic [7:0]  cnt_q;
    logic [15:0] lfsr_q;
    logic [31:0] mem [MEM_WORDS];

    logic [31:2] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [AW-1:0] req_idx;
    logic        is_write, is_tohost, is_ram, is_oob;
    logic [7:0]  wait_sel;
    logic [15:0] lfsr_next;
    logic        enter_resp, bus_we;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^mem_addr[1:0];

    // In IDLE a zero-wait request goes straight to RESP, so decode must see the live inputs.
    always_comb begin
        if (state_q == StIdle) begin
            req_addr  = mem_addr[31:2];
            req_wdata = mem_wdata;
            req_wstrb = mem_wstrb;
        end else begin
            req_addr  = addr_q;
            req_wdata = wdata_q;
            req_wstrb = wstrb_q;
        end
        req_idx   = req_addr[AW+1:2];
        is_write  = |req_wstrb;
        is_tohost = (req_addr == TOHOST_ADDR[31:2]);
        is_ram    = !is_tohost && (req_addr[31:AW+2] == '0);
        is_oob    = is_tohost ? (is_write && req_wstrb != 4'hF) : !is_ram;
        wait_sel  = 8'(MIN_WAIT) + (RAND_WAIT ? (lfsr_q[7:0] & WAIT_MASK) : 8'd0);
        lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        enter_resp = (state_q == StIdle && mem_valid && wait_sel == 8'd0) ||
                     (state_q == StWait && cnt_q == 8'd1);
        // Writes commit at the edge that ends RESP, so a reset held in RESP drops them.
        bus_we = (state_q == StResp) && !reset && is_ram && is_write;
    end

    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_data;
        end
        if (bus_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[req_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            instr_q      <= 1'b0;
            cnt_q        <= '0;
            lfsr_q       <= SEED;
            mem_ready    <= 1'b0;
            mem_rdata    <= '0;
            tohost_valid <= 1'b0;
            tohost_data  <= '0;
            err_oob      <= 1'b0;
            access_count <= '0;
            fetch_count  <= '0;
        end else begin
            mem_ready    <= 1'b0;
            tohost_valid <= 1'b0;
            if (enter_resp) begin
                mem_ready <= 1'b1;
                if (is_tohost) begin
                    if (!is_write) begin
                        mem_rdata <= '0;
                    end else if (req_wstrb == 4'hF) begin
                        tohost_valid <= 1'b1;
                        tohost_data  <= req_wdata;
                    end
                end else if (is_ram) begin
                    if (!is_write) mem_rdata <= mem[req_idx];
                end else if (!is_write) begin
                    mem_rdata <= 32'hDEAD_BEEF;
                end
                if (is_oob) err_oob <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (mem_valid) begin
                        addr_q  <= mem_addr[31:2];
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        instr_q <= mem_instr;
                        cnt_q   <= wait_sel;
                        lfsr_q  <= lfsr_next;
                        state_q <= (wait_sel == 8'd0) ? StResp : StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_q <= StResp;
                end
                StResp: begin
                    state_q <= StIdle;
                    if (access_count != 32'hFFFF_FFFF) access_count <= access_count + 32'd1;
                    if (instr_q && fetch_count != 32'hFFFF_FFFF) begin
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_wait_mem.sv
// Self-checking bench: a randomised-wait instance checked against a behavioural model, and a
// fixed-wait instance for latency, partial-mailbox and reset-abort scenarios.
module tb_picorv32_wait_mem;

    logic        clk = 1'b0;
    logic        reset_r, reset_f, valid_r, valid_f, instr;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        load_we;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    logic        ready_r, tv_r, err_r, ready_f, tv_f, err_f;
    logic [31:0] rdata_r, td_r, ac_r, fc_r, rdata_f, td_f, ac_f, fc_f;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the randomised instance.
    logic [31:0] m_ram [1024];
    logic [15:0] m_lfsr;
    logic [31:0] m_last_rd;
    logic        m_err;
    int          m_ac, m_fc;

    always #5 clk = ~clk;

    picorv32_wait_mem #(.MIN_WAIT(0), .MAX_WAIT(3), .RAND_WAIT(1'b1)) u_rnd (
        .clk(clk), .reset(reset_r), .mem_valid(valid_r), .mem_instr(instr), .mem_addr(addr),
        .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(ready_r), .mem_rdata(rdata_r),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .tohost_valid(tv_r), .tohost_data(td_r), .err_oob(err_r),
        .access_count(ac_r), .fetch_count(fc_r)
    );

    picorv32_wait_mem #(.MIN_WAIT(3), .MAX_WAIT(3), .RAND_WAIT(1'b0)) u_fix (
        .clk(clk), .reset(reset_f), .mem_valid(valid_f), .mem_instr(instr), .mem_addr(addr),
        .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(ready_f), .mem_rdata(rdata_f),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .tohost_valid(tv_f), .tohost_data(td_f), .err_oob(err_f),
        .access_count(ac_f), .fetch_count(fc_f)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic backdoor(input int idx, input logic [31:0] d);
        load_we = 1'b1; load_addr = idx[9:0]; load_data = d;
        @(posedge clk); #1;
        load_we = 1'b0;
        m_ram[idx] = d;
    endtask

    // Issue one request and wait (bounded) for mem_ready; lat = cycles from acceptance edge.
    task automatic access(input bit fix, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit ins,
                          output logic [31:0] rd, output int lat, output bit tv);
        addr = a; wdata = d; wstrb = s; instr = ins;
        rd = 'x; tv = 1'b0; lat = -1;
        if (fix) valid_f = 1'b1; else valid_r = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if ((fix ? ready_f : ready_r) === 1'b1) begin
                lat = i;
                rd  = fix ? rdata_f : rdata_r;
                tv  = fix ? tv_f : tv_r;
                break;
            end
        end
        valid_r = 1'b0; valid_f = 1'b0;
        @(posedge clk); #1;
    endtask

    // Access on the randomised instance, advancing the model and producing expectations.
    task automatic rnd_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input bit ins, output logic [31:0] rd, output int lat,
                              output bit tv, output int exp_lat, output logic [31:0] exp_rd);
        int unsigned byte_addr;
        int idx;
        byte_addr = a & 32'hFFFF_FFFC;
        idx = (a >> 2) & 1023;
        exp_lat = 1 + int'(m_lfsr & 16'h3);
        m_lfsr = lfsr_step(m_lfsr);
        access(1'b0, a, d, s, ins, rd, lat, tv);
        if (byte_addr == 32'h1000) begin
            if (s == 4'h0) m_last_rd = 32'h0;
            else if (s != 4'hF) m_err = 1'b1;
        end else if (byte_addr < 4 * 1024) begin
            if (s == 4'h0) m_last_rd = m_ram[idx];
            else for (int b = 0; b < 4; b++) if (s[b]) m_ram[idx][8*b +: 8] = d[8*b +: 8];
        end else begin
            m_err = 1'b1;
            if (s == 4'h0) m_last_rd = 32'hDEAD_BEEF;
        end
        exp_rd = m_last_rd;
        m_ac++;
        if (ins) m_fc++;
    endtask

    task automatic test_reset;
        valid_r = 0; valid_f = 0; instr = 0; addr = 0; wdata = 0; wstrb = 0;
        load_we = 0; load_addr = 0; load_data = 0;
        reset_r = 1; reset_f = 1;
        repeat (3) @(posedge clk);
        #1;
        reset_r = 0; reset_f = 0;
        m_lfsr = 16'hACE1; m_last_rd = 0; m_err = 0; m_ac = 0; m_fc = 0;
        n_tests++;
        if ({ready_r, tv_r, err_r, ready_f} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {ready_r, tv_r, err_r, ready_f});
        end
        n_tests++;
        if (rdata_r !== 32'h0 || td_r !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: rdata=%h tohost=%h want 0", rdata_r, td_r);
        end
        n_tests++;
        if (ac_r !== 32'h0 || fc_r !== 32'h0) begin
            n_fail++; $display("FAIL reset_counts: access=%0d fetch=%0d want 0", ac_r, fc_r);
        end
        for (int i = 0; i < 64; i++) backdoor(i, $urandom);
    endtask

    task automatic test_fixed_wait;
        logic [31:0] rd; int lat; bit tv;
        access(1'b1, 32'h8, 32'h0, 4'h0, 1'b0, rd, lat, tv);
        n_tests++;
        if (lat != 4) begin n_fail++; $display("FAIL fixed_latency: got %0d want 4", lat); end
        n_tests++;
        if (rd !== m_ram[2]) begin n_fail++; $display("FAIL fixed_rdata: got %h want %h", rd, m_ram[2]); end
        n_tests++;
        if (ready_f !== 1'b0) begin n_fail++; $display("FAIL fixed_single_pulse: ready=%b want 0", ready_f); end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] rd; int lat; bit tv;
        addr = 32'h1C; wdata = ~m_ram[7]; wstrb = 4'hF; instr = 0; valid_f = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        valid_f = 0; reset_f = 1;
        @(posedge clk); #1;
        reset_f = 0;
        n_tests++;
        if (ready_f !== 1'b0 || ac_f !== 32'h0) begin
            n_fail++; $display("FAIL abort_state: ready=%b access=%0d want 0/0", ready_f, ac_f);
        end
        access(1'b1, 32'h1C, 32'h0, 4'h0, 1'b0, rd, lat, tv);
        n_tests++;
        if (rd !== m_ram[7] || lat != 4) begin
            n_fail++; $display("FAIL abort_write_dropped: got %h lat %0d want %h lat 4", rd, lat, m_ram[7]);
        end
    endtask

    task automatic test_partial_mailbox;
        logic [31:0] rd; int lat; bit tv;
        access(1'b1, 32'h1000, 32'h1234_5678, 4'b0011, 1'b0, rd, lat, tv);
        n_tests++;
        if (tv !== 1'b0 || err_f !== 1'b1 || td_f !== 32'h0) begin
            n_fail++; $display("FAIL partial_mailbox: tv=%b err=%b td=%h want 0/1/0", tv, err_f, td_f);
        end
    endtask

    task automatic test_program;
        logic [31:0] rd, er; int lat, el; bit tv;
        logic [31:0] prog [3];
        prog[0] = 32'h0010_0093; prog[1] = 32'h0010_2023; prog[2] = 32'h0010_0073;
        for (int i = 0; i < 3; i++) backdoor(i, prog[i]);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) rnd_access(32'h0, 32'h1, 4'hF, 1'b0, rd, lat, tv, el, er);
            else rnd_access(32'((i == 3 ? 2 : i) * 4), 32'h0, 4'h0, 1'b1, rd, lat, tv, el, er);
            n_tests++;
            if (lat != el || (i != 2 && rd !== prog[i == 3 ? 2 : i])) begin
                n_fail++; $display("FAIL prog_step%0d: got %h lat %0d want lat %0d", i, rd, lat, el);
            end
        end
        n_tests++;
        if (ac_r !== 32'd4 || fc_r !== 32'd3) begin
            n_fail++; $display("FAIL prog_counts: access=%0d fetch=%0d want 4/3", ac_r, fc_r);
        end
        rnd_access(32'h0, 32'h0, 4'h0, 1'b0, rd, lat, tv, el, er);
        n_tests++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL prog_store: got %h want 00000001", rd); end
    endtask

    task automatic test_mailbox;
        logic [31:0] rd, er; int lat, el; bit tv;
        rnd_access(32'h1000, 32'hCAFE_F00D, 4'hF, 1'b0, rd, lat, tv, el, er);
        n_tests++;
        if (tv !== 1'b1 || lat != el) begin
            n_fail++; $display("FAIL mailbox_pulse: tv=%b lat=%0d want 1 lat %0d", tv, lat, el);
        end
        n_tests++;
        if (tv_r !== 1'b0 || td_r !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL mailbox_data: tv=%b td=%h want 0 cafef00d", tv_r, td_r);
        end
        rnd_access(32'h0, 32'h0, 4'h0, 1'b0, rd, lat, tv, el, er);
        n_tests++;
        if (rd !== er || err_r !== 1'b0) begin
            n_fail++; $display("FAIL mailbox_ram_untouched: got %h err %b want %h err 0", rd, err_r, er);
        end
    endtask

    task automatic test_oob;
        logic [31:0] rd, er; int lat, el; bit tv;
        rnd_access(32'h2000, 32'h0, 4'h0, 1'b0, rd, lat, tv, el, er);
        n_tests++;
        if (rd !== 32'hDEAD_BEEF || err_r !== 1'b1) begin
            n_fail++; $display("FAIL oob_read: got %h err %b want deadbeef err 1", rd, err_r);
        end
        rnd_access(32'h10, 32'h0, 4'h0, 1'b0, rd, lat, tv, el, er);
        n_tests++;
        if (err_r !== 1'b1 || rd !== er) begin
            n_fail++; $display("FAIL oob_sticky: err %b rd %h want 1 %h", err_r, rd, er);
        end
    endtask

    task automatic test_byte_write;
        logic [31:0] rd, er; int lat, el; bit tv;
        backdoor(5, 32'h1122_3344);
        rnd_access(32'h14, 32'h00AB_0000, 4'b0100, 1'b0, rd, lat, tv, el, er);
        rnd_access(32'h14, 32'h0, 4'h0, 1'b0, rd, lat, tv, el, er);
        n_tests++;
        if (rd !== 32'h11AB_3344) begin n_fail++; $display("FAIL byte_write: got %h want 11ab3344", rd); end
    endtask

    task automatic test_random;
        logic [31:0] rd, er, a, d; logic [3:0] s; int lat, el; bit tv;
        int hist [5];
        for (int k = 0; k < 5; k++) hist[k] = 0;
        for (int n = 0; n < 1000; n++) begin
            a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            d = $urandom;
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            rnd_access(a, d, s, 1'($urandom_range(0, 1)), rd, lat, tv, el, er);
            if (lat >= 1 && lat <= 4) hist[lat]++;
            n_tests++;
            if (lat != el) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, el); end
            if (s == 4'h0) begin
                n_tests++;
                if (rd !== er) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h want %h", n, rd, er); end
            end
        end
        n_tests++;
        if (hist[1] == 0 || hist[2] == 0 || hist[3] == 0 || hist[4] == 0) begin
            n_fail++;
            $display("FAIL rand_coverage: hist %0d %0d %0d %0d want all nonzero", hist[1], hist[2], hist[3], hist[4]);
        end
        n_tests++;
        if (ac_r !== 32'(m_ac) || fc_r !== 32'(m_fc)) begin
            n_fail++; $display("FAIL rand_counts: got %0d/%0d want %0d/%0d", ac_r, fc_r, m_ac, m_fc);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_wait();
        test_reset_mid_wait();
        test_partial_mailbox();
        test_program();
        test_mailbox();
        test_oob();
        test_byte_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule
